// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges ALU and long-latency results onto the register file write port.
// Long-latency results queue in an in-order FIFO; a pending scoreboard tracks outstanding destinations.
module wb_write_arbiter #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      alu_we,
   input  logic [ADDR_W-1:0]         alu_addr,
   input  logic [DATA_W-1:0]         alu_data,
   input  logic                      lu_valid,
   output logic                      lu_ready,
   input  logic [ADDR_W-1:0]         lu_addr,
   input  logic [DATA_W-1:0]         lu_data,
   input  logic                      issue_valid,
   input  logic [ADDR_W-1:0]         issue_addr,
   output logic [(1<<ADDR_W)-1:0]    pending_mask,
   output logic                      stall_req,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic                      rf_we,
   output logic [ADDR_W-1:0]         rf_addr,
   output logic [DATA_W-1:0]         rf_data
);
   localparam int PW = $clog2(DEPTH);
   localparam int NR = 1 << ADDR_W;
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
   localparam logic [NR-1:0] ONE = NR'(1);
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic push, pop, alu_sel;
   logic [ADDR_W-1:0] head_addr;
   logic [NR-1:0] set_mask, clr_mask;
   assign lu_ready  = fifo_count < FULL;
   assign stall_req = fifo_count == FULL;
   assign push      = lu_valid && lu_ready;
   // a full FIFO outranks the ALU so the long-latency unit can always drain
   assign alu_sel   = !stall_req && alu_we && alu_addr != '0;
   assign pop       = !alu_sel && fifo_count != '0;
   assign head_addr = addr_mem[rd_ptr];
   assign set_mask  = (issue_valid && issue_addr != '0) ? ONE << issue_addr : '0;
   assign clr_mask  = (pop && head_addr != '0) ? ONE << head_addr : '0;
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= lu_addr;
         data_mem[wr_ptr] <= lu_data;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_count   <= '0;
         pending_mask <= '0;
         rf_we        <= 1'b0;
         rf_addr      <= '0;
         rf_data      <= '0;
      end else begin
         wr_ptr       <= push ? wr_ptr + PW'(1) : wr_ptr;
         rd_ptr       <= pop ? rd_ptr + PW'(1) : rd_ptr;
         fifo_count   <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);
         // set is applied after clear so a same-edge reissue keeps the bit
         pending_mask <= (pending_mask & ~clr_mask) | set_mask;
         rf_we        <= alu_sel || (pop && head_addr != '0);
         if (alu_sel) begin
            rf_addr <= alu_addr;
            rf_data <= alu_data;
         end else if (pop) begin
            rf_addr <= head_addr;
            rf_data <= data_mem[rd_ptr];
         end
      end
   end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: table-driven ALU vectors plus scripted FIFO, scoreboard and reset sequences.
// Every observed register-file write is matched against a queue of expected writes.
module tb_wb_write_arbiter;
   logic        clk = 0, rst = 0;
   logic        alu_we = 0, lu_valid = 0, issue_valid = 0;
   logic [4:0]  alu_addr = 0, lu_addr = 0, issue_addr = 0;
   logic [31:0] alu_data = 0, lu_data = 0;
   logic        lu_ready, stall_req, rf_we;
   logic [31:0] pending_mask, rf_data;
   logic [2:0]  fifo_count;
   logic [4:0]  rf_addr;
   int checks = 0, errors = 0;
   typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;
   typedef struct packed {
      logic we; logic [4:0] a; logic [31:0] d;
      logic exp_we; logic [4:0] exp_a; logic [31:0] exp_d;
   } vec_t;
   wr_t  exp_q[$];
   vec_t tbl[6];

   wb_write_arbiter #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .alu_we(alu_we), .alu_addr(alu_addr), .alu_data(alu_data),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
      .issue_valid(issue_valid), .issue_addr(issue_addr), .pending_mask(pending_mask),
      .stall_req(stall_req), .fifo_count(fifo_count), .rf_we(rf_we), .rf_addr(rf_addr),
      .rf_data(rf_data));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", n, act, exp);
      end
   endtask

   // advance one edge, then match any write against the expected queue
   task automatic tick();
      wr_t e;
      @(posedge clk);
      #1;
      if (rf_we) begin
         if (exp_q.size() == 0) chk("spurious_wr", rf_we, 0);
         else begin
            e = exp_q.pop_front();
            chk("sb_addr", rf_addr, e.a);
            chk("sb_data", rf_data, e.d);
         end
      end
   endtask

   initial begin
      tbl[0] = '{1'b1, 5'd5,  32'h00001234, 1'b1, 5'd5,  32'h00001234};
      tbl[1] = '{1'b0, 5'd7,  32'h00000055, 1'b0, 5'd5,  32'h00001234};
      tbl[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd5,  32'h00001234};
      tbl[3] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd31, 32'hA5A5A5A5};
      tbl[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h00000000};
      tbl[5] = '{1'b0, 5'd0,  32'h00000000, 1'b0, 5'd1,  32'h00000000};
      #2;
      chk("rst_we", rf_we, 0);
      chk("rst_addr", rf_addr, 0);
      chk("rst_data", rf_data, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_pending", pending_mask, 0);
      chk("rst_ready", lu_ready, 1);
      chk("rst_stall", stall_req, 0);
      @(posedge clk);
      #1 rst = 1;
      // ALU-only vectors: write, hold, r0 suppression
      for (int i = 0; i < 6; i++) begin
         alu_we = tbl[i].we; alu_addr = tbl[i].a; alu_data = tbl[i].d;
         if (tbl[i].exp_we) exp_q.push_back('{tbl[i].exp_a, tbl[i].exp_d});
         tick();
         chk("tbl_we", rf_we, tbl[i].exp_we);
         chk("tbl_addr", rf_addr, tbl[i].exp_a);
         chk("tbl_data", rf_data, tbl[i].exp_d);
      end
      alu_we = 0;
      // long-latency path with ALU idle
      issue_valid = 1; issue_addr = 8;
      tick();
      issue_valid = 0;
      chk("ll_pend_set", pending_mask, 32'h100);
      lu_valid = 1; lu_addr = 8; lu_data = 32'hDEADBEEF;
      exp_q.push_back('{5'd8, 32'hDEADBEEF});
      tick();
      lu_valid = 0;
      chk("ll_count1", fifo_count, 1);
      chk("ll_no_we_yet", rf_we, 0);
      tick();
      chk("ll_we", rf_we, 1);
      chk("ll_pend_clr", pending_mask, 0);
      chk("ll_count0", fifo_count, 0);
      tick();
      chk("ll_we_drop", rf_we, 0);
      // FIFO entry for r0 pops without a write
      lu_valid = 1; lu_addr = 0; lu_data = 32'h77;
      tick();
      lu_valid = 0;
      tick();
      chk("r0_pop_we", rf_we, 0);
      chk("r0_pop_count", fifo_count, 0);
      // fill the FIFO while the ALU owns the port
      for (int i = 0; i < 4; i++) begin
         alu_we = 1; alu_addr = 5'(1 + i); alu_data = 32'h100 + i;
         lu_valid = 1; lu_addr = 5'(9 + i); lu_data = 32'h900 + i;
         exp_q.push_back('{5'(1 + i), 32'h100 + i});
         tick();
      end
      for (int i = 0; i < 4; i++) exp_q.push_back('{5'(9 + i), 32'h900 + i});
      chk("full_count", fifo_count, 4);
      chk("full_ready", lu_ready, 0);
      chk("full_stall", stall_req, 1);
      // ALU write and lu offer while full are both dropped
      alu_addr = 20; alu_data = 32'hBAD; lu_addr = 13; lu_data = 32'hBAD;
      tick();
      alu_we = 0; lu_valid = 0;
      chk("drain_count3", fifo_count, 3);
      chk("drain_ready", lu_ready, 1);
      chk("drain_stall", stall_req, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("drain_we", rf_we, 1);
      end
      chk("drain_count0", fifo_count, 0);
      chk("drain_sb_empty", exp_q.size(), 0);
      // queue three results behind a busy ALU, then reset between edges
      for (int i = 0; i < 3; i++) begin
         issue_valid = 1; issue_addr = 5'(8 + i);
         alu_we = 1; alu_addr = 3; alu_data = 32'h300 + i;
         lu_valid = 1; lu_addr = 5'(8 + i); lu_data = 32'h800 + i;
         exp_q.push_back('{5'd3, 32'h300 + i});
         tick();
      end
      alu_we = 0; lu_valid = 0; issue_valid = 0;
      chk("pre_rst_count", fifo_count, 3);
      chk("pre_rst_pending", pending_mask, 32'h700);
      rst = 0;
      #1;
      chk("mid_rst_we", rf_we, 0);
      chk("mid_rst_addr", rf_addr, 0);
      chk("mid_rst_data", rf_data, 0);
      chk("mid_rst_count", fifo_count, 0);
      chk("mid_rst_pending", pending_mask, 0);
      chk("mid_rst_ready", lu_ready, 1);
      tick();
      tick();
      rst = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_we", rf_we, 0);
      end
      chk("post_rst_count", fifo_count, 0);
      // same-edge set and clear of r12: set wins
      issue_valid = 1; issue_addr = 12;
      tick();
      issue_valid = 0;
      chk("col_pend_set", pending_mask, 32'h1000);
      lu_valid = 1; lu_addr = 12; lu_data = 32'hC0C0;
      tick();
      lu_valid = 0;
      issue_valid = 1; issue_addr = 12;
      exp_q.push_back('{5'd12, 32'hC0C0});
      tick();
      issue_valid = 0;
      chk("col_we", rf_we, 1);
      chk("col_pend_keep", pending_mask, 32'h1000);
      tick();
      chk("final_sb_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer side of the MIPS register file write port (RegWrite / Rd_addr / Rd_data).
- Merges two result sources onto that single write port:
  - the in-order ALU/writeback pipeline, one result per cycle, no handshake;
  - the long-latency unit (load/mul/div), valid/ready handshake, buffered in a small in-order FIFO.
- Keeps a per-register pending scoreboard so decode can stall on registers with outstanding long-latency results.

Parameters:
- DEPTH, 4: FIFO entries for long-latency results; power of 2, ≥2.
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- alu_we  input  1  ALU pipeline result valid this cycle.
- alu_addr  input  ADDR_W  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- lu_valid  input  1  long-latency result offered.
- lu_ready  output  1  FIFO can accept; equals (count < DEPTH).
- lu_addr  input  ADDR_W  long-latency destination register.
- lu_data  input  DATA_W  long-latency result.
- issue_valid  input  1  long-latency op issued this cycle.
- issue_addr  input  ADDR_W  its destination register.
- pending_mask  output  2**ADDR_W  bit i = 1 while register i awaits a long-latency result.
- stall_req  output  1  FIFO full; equals (count == DEPTH).
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- rf_we  output  1  to register file RegWrite; registered.
- rf_addr  output  ADDR_W  to register file Rd_addr; registered.
- rf_data  output  DATA_W  to register file Rd_data; registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - rf_we, rf_addr, rf_data = 0.
  - FIFO emptied: count=0, pointers=0.
  - pending_mask = 0.
  - Consequently lu_ready=1, stall_req=0.
  - Reset mid-operation discards all queued results; no rf write occurs after release until new input arrives.
- lu_ready and stall_req are decoded from the registered count only; there is no combinational path from any input.
- Push: on an edge with lu_valid && lu_ready, {lu_addr, lu_data} is written at the tail.
  - lu_addr = 0 is still pushed and popped, but the pop produces rf_we=0.
- Write-port arbitration, evaluated each cycle; the selected source loads rf_* at the next edge (1-cycle latency):
  1. stall_req=0 and alu_we=1 and alu_addr≠0: load ALU result, rf_we=1. FIFO does not pop.
  2. Otherwise, if count>0: pop head; rf_we = (head addr ≠ 0).
  3. Otherwise: rf_we=0. rf_addr and rf_data hold their previous values.
- When stall_req=1, the FIFO has priority. The upstream pipeline must hold alu_we=0; any ALU write presented anyway is discarded.
- Address 0 is never written from either source (rf_we=0).
- Simultaneous push and pop in one cycle: count unchanged; a push into a full FIFO cannot occur because lu_ready=0.
- Minimum long-latency latency: accept at edge E, pop at edge E+1 if the ALU is idle, so rf_we is high in the cycle after E+1.
- Ordering: FIFO results drain in strict acceptance order. Pointers wrap modulo DEPTH.
- Scoreboard:
  - issue_valid && issue_addr≠0 sets pending_mask[issue_addr] at the edge.
  - A FIFO pop with head addr ≠ 0 clears pending_mask[head addr] at the same edge rf_* loads.
  - Set and clear of the same bit on the same edge: set wins, bit stays 1.
  - An ALU write to a pending register does not change pending_mask; write-after-write ordering is decode's responsibility.
- pending_mask[0] is always 0.

Test Plan:
- Single ALU write: alu_we=1, alu_addr=5, alu_data=0x00001234 for one cycle → next cycle rf_we=1, rf_addr=5, rf_data=0x00001234; following cycle rf_we=0.
- ALU write to register 0: alu_we=1, alu_addr=0, alu_data=0xFFFFFFFF → rf_we stays 0 throughout.
- Long-latency path, ALU idle:
  - issue_valid=1, issue_addr=8 → pending_mask[8]=1 from the next cycle.
  - Later, lu push {8, 0xDEADBEEF} accepted at edge E → rf_we=1, rf_addr=8, rf_data=0xDEADBEEF after edge E+1; pending_mask[8]=0 from that same edge.
- Full FIFO and priority:
  - ALU writes r1..r4 on consecutive cycles while lu pushes r9..r12 → FIFO count reaches 4, lu_ready=0, stall_req=1.
  - With alu_we then held 0 → rf receives r9, r10, r11, r12 in order on 4 consecutive cycles; lu_ready=1 once count=3.
- Set/clear collision: FIFO head addr=12 pops on the same edge issue_valid=1, issue_addr=12 → pending_mask[12] remains 1; rf write to r12 still occurs.
- Reset mid-operation:
  - 3 entries queued and pending_mask=0x00000700; assert rst=0 between edges → rf_we, rf_addr, rf_data, fifo_count, pending_mask read 0 immediately, lu_ready=1.
  - After release with no input → no rf_we pulse.
